// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stall bus type,
// freeze polarity constants, stage indices and FSM state encoding.
package pipe_stall_ctrl_pkg;

  localparam int STALL_BUS_W = 6;
  typedef logic [STALL_BUS_W-1:0] stall_bus_t;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [2:0] STG_PC  = 3'd0;
  localparam logic [2:0] STG_IF  = 3'd1;
  localparam logic [2:0] STG_ID  = 3'd2;
  localparam logic [2:0] STG_EX  = 3'd3;
  localparam logic [2:0] STG_MEM = 3'd4;
  localparam logic [2:0] STG_WB  = 3'd5;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-controller bus: stall requests and redirect in, freeze mask,
// flush pulse, redirect PC and statistics out.
interface pipe_stall_ctrl_if #(
  parameter int NREQ    = 3,
  parameter int STALL_W = 6,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 32
);
  logic [NREQ-1:0]    stallreq;
  logic               excp_req;
  logic [PC_W-1:0]    excp_pc;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [PC_W-1:0]    new_pc;
  logic               stall_timeout;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output stallreq, excp_req, excp_pc,
    input  stall, flush, new_pc, stall_timeout, stall_cnt
  );

  modport slave (
    input  stallreq, excp_req, excp_pc,
    output stall, flush, new_pc, stall_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; at_max flags the ceiling.
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max
);
  logic [W-1:0] r_cnt;

  assign at_max = (r_cnt == MAX);
  assign cnt    = r_cnt;

  // Count up on inc, stop at MAX, clear has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !at_max) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: merges stall requests into a freeze mask,
// converts redirect requests into a one-cycle flush, keeps stall stats.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int               STALL_W   = STALL_BUS_W,
  parameter int               NREQ      = 3,
  parameter logic [3*NREQ-1:0] REQ_STAGE = {STG_EX, STG_ID, STG_IF},
  parameter int               PC_W      = 32,
  parameter int               MAX_STALL = 64,
  parameter int               CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus
);
  localparam int RUN_W = $clog2(MAX_STALL + 1);

  state_e             r_state;
  logic               r_flush;
  logic [PC_W-1:0]    r_new_pc;
  logic               r_excp_d;
  logic               r_timeout;

  logic               w_any;
  logic [2:0]         w_k;
  logic [STALL_W-1:0] w_mask;
  logic [STALL_W-1:0] w_stall;
  logic               w_stall_nz;
  logic               w_rise;
  logic [RUN_W-1:0]   w_run_cnt;
  logic               w_run_at_max;
  logic [CNT_W-1:0]   w_stall_cnt;
  logic               w_cnt_at_max;

  // Deepest requesting stage, then a thermometer mask up to it.
  always_comb begin
    w_any  = 1'b0;
    w_k    = 3'd0;
    w_mask = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (bus.stallreq[j] && (!w_any || (REQ_STAGE[3*j +: 3] > w_k))) begin
        w_k   = REQ_STAGE[3*j +: 3];
        w_any = 1'b1;
      end else begin
        w_k   = w_k;
      end
    end
    for (int i = 0; i < STALL_W; i++) begin
      w_mask[i] = (w_any && (3'(i) <= w_k)) ? STOP : NOSTOP;
    end
  end

  // Freeze mask is suppressed while in reset and during the flush cycle.
  always_comb begin
    if (!rst || (r_state == ST_FLUSH)) begin
      w_stall = '0;
    end else begin
      w_stall = w_mask;
    end
  end

  assign w_stall_nz = |w_stall;
  assign w_rise     = bus.excp_req & ~r_excp_d;

  // RUN/FLUSH sequencer with registered flush pulse and redirect capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_flush  <= 1'b0;
      r_new_pc <= '0;
      r_excp_d <= 1'b0;
    end else begin
      r_excp_d <= bus.excp_req;
      case (r_state)
        ST_RUN: begin
          if (w_rise) begin
            r_state  <= ST_FLUSH;
            r_flush  <= 1'b1;
            r_new_pc <= bus.excp_pc;
          end else begin
            r_state  <= ST_RUN;
            r_flush  <= 1'b0;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
        end
        default: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W   (RUN_W),
    .MAX (RUN_W'(MAX_STALL))
  ) u_run_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (w_stall_nz),
    .clr    (~w_stall_nz),
    .cnt    (w_run_cnt),
    .at_max (w_run_at_max)
  );

  sat_counter #(
    .W   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (w_stall_nz),
    .clr    (1'b0),
    .cnt    (w_stall_cnt),
    .at_max (w_cnt_at_max)
  );

  // Sticky watchdog; sets on the same edge the run length reaches the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout <= 1'b0;
    end else if (w_run_at_max ||
                 (w_stall_nz && (w_run_cnt == RUN_W'(MAX_STALL - 1)))) begin
      r_timeout <= 1'b1;
    end else begin
      r_timeout <= r_timeout;
    end
  end

  assign bus.stall         = w_stall;
  assign bus.flush         = r_flush;
  assign bus.new_pc        = r_new_pc;
  assign bus.stall_timeout = r_timeout;
  assign bus.stall_cnt     = w_stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; a second instance with a 4-bit
// statistics counter shares the stimulus for the saturation check.
module tb_pipe_stall_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_stall_ctrl_if #(.NREQ(3), .STALL_W(6), .PC_W(32), .CNT_W(32)) bus ();
  pipe_stall_ctrl_if #(.NREQ(3), .STALL_W(6), .PC_W(32), .CNT_W(4))  sbus ();

  pipe_stall_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_stall_ctrl #(.CNT_W(4)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  assign sbus.stallreq = bus.stallreq;
  assign sbus.excp_req = bus.excp_req;
  assign sbus.excp_pc  = bus.excp_pc;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    // Reset with random inputs
    bus.stallreq = 3'($urandom_range(7, 1));
    bus.excp_req = 1'b1;
    bus.excp_pc  = 32'($urandom);
    repeat (3) tick();
    chk("rst_stall",   64'(bus.stall), 64'h0);
    chk("rst_flush",   64'(bus.flush), 64'h0);
    chk("rst_new_pc",  64'(bus.new_pc), 64'h0);
    chk("rst_timeout", 64'(bus.stall_timeout), 64'h0);
    chk("rst_cnt",     64'(bus.stall_cnt), 64'h0);
    bus.stallreq = 3'b000;
    bus.excp_req = 1'b0;
    bus.excp_pc  = 32'h0;
    #1;
    rst = 1'b1;
    tick();
    chk("rel_stall", 64'(bus.stall), 64'h0);
    chk("rel_flush", 64'(bus.flush), 64'h0);

    // Mask merging
    bus.stallreq = 3'b010; #1; chk("mask_010", 64'(bus.stall), 64'h07);
    bus.stallreq = 3'b101; #1; chk("mask_101", 64'(bus.stall), 64'h0F);
    bus.stallreq = 3'b001; #1; chk("mask_001", 64'(bus.stall), 64'h03);
    bus.stallreq = 3'b000; #1; chk("mask_000", 64'(bus.stall), 64'h00);
    tick();

    // Flush: request cycle, flush cycle, then held request
    bus.stallreq = 3'b100;
    bus.excp_req = 1'b1;
    bus.excp_pc  = 32'hBFC0_0380;
    #1;
    chk("fl_req_stall", 64'(bus.stall), 64'h0F);
    chk("fl_req_flush", 64'(bus.flush), 64'h0);
    tick();
    chk("fl_flush", 64'(bus.flush), 64'h1);
    chk("fl_stall", 64'(bus.stall), 64'h0);
    chk("fl_pc",    64'(bus.new_pc), 64'hBFC0_0380);
    bus.excp_pc = 32'h1111_2222;
    tick();
    chk("fl_after_flush", 64'(bus.flush), 64'h0);
    chk("fl_after_stall", 64'(bus.stall), 64'h0F);
    chk("fl_after_pc",    64'(bus.new_pc), 64'hBFC0_0380);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fl_held", 64'(bus.flush), 64'h0);
    end
    bus.excp_req = 1'b0;
    tick();
    chk("fl_low", 64'(bus.flush), 64'h0);
    chk("fl_low_pc", 64'(bus.new_pc), 64'hBFC0_0380);
    bus.excp_req = 1'b1;
    bus.excp_pc  = 32'h0000_1234;
    tick();
    chk("rearm_flush", 64'(bus.flush), 64'h1);
    chk("rearm_pc",    64'(bus.new_pc), 64'h0000_1234);
    bus.excp_req = 1'b0;
    bus.stallreq = 3'b000;
    tick();
    chk("rearm_done", 64'(bus.flush), 64'h0);

    // Watchdog trip at 64 consecutive stalled cycles
    pulse_reset();
    bus.stallreq = 3'b001;
    repeat (63) tick();
    chk("wd_63", 64'(bus.stall_timeout), 64'h0);
    tick();
    chk("wd_64", 64'(bus.stall_timeout), 64'h1);
    bus.stallreq = 3'b000;
    repeat (3) tick();
    chk("wd_sticky", 64'(bus.stall_timeout), 64'h1);

    // 63 + gap + 63 must not trip
    pulse_reset();
    bus.stallreq = 3'b001;
    repeat (63) tick();
    bus.stallreq = 3'b000;
    tick();
    bus.stallreq = 3'b001;
    repeat (63) tick();
    chk("wd_gap", 64'(bus.stall_timeout), 64'h0);
    chk("cnt_126", 64'(bus.stall_cnt), 64'd126);
    bus.stallreq = 3'b000;
    tick();

    // Statistics saturation
    pulse_reset();
    bus.stallreq = 3'b010;
    repeat (20) tick();
    chk("sat_4bit", 64'(sbus.stall_cnt), 64'hF);
    chk("cnt_20",   64'(bus.stall_cnt), 64'd20);
    bus.stallreq = 3'b000;
    tick();

    // Async reset during the flush cycle
    bus.excp_req = 1'b1;
    bus.excp_pc  = 32'hCAFE_0000;
    tick();
    chk("ar_flush_on", 64'(bus.flush), 64'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_flush_off", 64'(bus.flush), 64'h0);
    chk("ar_pc",        64'(bus.new_pc), 64'h0);
    bus.excp_req = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    chk("ar_after", 64'(bus.flush), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
